// File: rtl/spi_word_serializer_pkg.sv
// Shared types and constants for the SPI word serializer slice.
// Optional feature macro used elsewhere: SPI_WORD_SERIALIZER_UNDERRUN_EN.
package spi_word_serializer_pkg;

    localparam int unsigned SpiWordWidth = 32;
    localparam int unsigned ClkDivMax    = 255;
    localparam int unsigned ClkDivW      = $clog2(ClkDivMax + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StStall,
        StGap
    } spi_ser_state_t;

endpackage

// File: rtl/spi_word_serializer_if.sv
// Word handshake plus SPI pins for one serializer channel.
// SPI_WORD_SERIALIZER_UNDERRUN_EN adds the sticky underrun flag.
interface spi_word_serializer_if
    import spi_word_serializer_pkg::*;
#(
    parameter int unsigned WordWidth = SpiWordWidth
);

    logic [WordWidth-1:0] data;
    logic                 valid;
    logic                 last;
    logic                 ready;
    logic                 sclk;
    logic                 mosi;
    logic                 cs_n;
    logic                 busy;
    logic                 frame_done;
`ifdef SPI_WORD_SERIALIZER_UNDERRUN_EN
    logic                 underrun;

    modport master (
        output data, valid, last,
        input  ready, sclk, mosi, cs_n, busy, frame_done, underrun
    );

    modport slave (
        input  data, valid, last,
        output ready, sclk, mosi, cs_n, busy, frame_done, underrun
    );
`else
    modport master (
        output data, valid, last,
        input  ready, sclk, mosi, cs_n, busy, frame_done
    );

    modport slave (
        input  data, valid, last,
        output ready, sclk, mosi, cs_n, busy, frame_done
    );
`endif

endinterface

// File: rtl/spi_word_serializer_clk_divider.sv
// SCLK phase counter: ClkDiv cycles per half period, rise/fall strobes at the
// end of the low/high half; load restarts a fresh low half.
module spi_word_serializer_clk_divider
    import spi_word_serializer_pkg::*;
#(
    parameter int unsigned ClkDiv = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam logic [ClkDivW-1:0] CntMax = ClkDivW'(ClkDiv - 1);

    logic [ClkDivW-1:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic               tick;

    assign tick = en && (cnt_q == CntMax);
    assign rise = tick && !phase_q;
    assign fall = tick && phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end else if (en) begin
            cnt_d = cnt_q + ClkDivW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_word_serializer.sv
// Serializes handshaked words MSB-first as SPI mode 0 frames with a CS gap.
// Define SPI_WORD_SERIALIZER_UNDERRUN_EN to add the sticky underrun output.
module spi_word_serializer
    import spi_word_serializer_pkg::*;
#(
    parameter int unsigned WordWidth = SpiWordWidth,
    parameter int unsigned ClkDiv    = 2,
    parameter int unsigned CsGap     = 4
) (
    input logic                  clk,
    input logic                  rst,
    spi_word_serializer_if.slave bus
);

    localparam int unsigned BitW = $clog2(WordWidth);
    localparam int unsigned GapW = (CsGap > 1) ? $clog2(CsGap) : 1;

    spi_ser_state_t       state_q, state_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [WordWidth-1:0] hold_data_q;
    logic                 hold_last_q;
    logic                 ready_q;
    logic [WordWidth-1:0] shift_q, shift_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 cur_last_q, cur_last_d;
    logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 sclk_q, sclk_d;
    logic                 accept, drain;
    logic                 div_load, div_en, div_rise, div_fall;

    assign accept       = bus.valid && ready_q;
    assign hold_valid_d = accept || (hold_valid_q && !drain);
    assign div_en       = (state_q == StShift);

    spi_word_serializer_clk_divider #(
        .ClkDiv(ClkDiv)
    ) u_clk_divider (
        .clk (clk),
        .rst (rst),
        .load(div_load),
        .en  (div_en),
        .rise(div_rise),
        .fall(div_fall)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        cur_last_d   = cur_last_q;
        gap_cnt_d    = gap_cnt_q;
        frame_done_d = 1'b0;
        sclk_d       = sclk_q;
        drain        = 1'b0;
        div_load     = 1'b0;

        unique case (state_q)
            StIdle: drain = hold_valid_q;
            StShift: begin
                if (div_rise) begin
                    sclk_d = 1'b1;
                end
                // Bit 0 is never shifted out so MOSI keeps it through a stall.
                if (div_fall) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q != '0) begin
                        shift_d   = {shift_q[WordWidth-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - BitW'(1);
                    end else if (cur_last_q) begin
                        state_d      = StGap;
                        gap_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else if (hold_valid_q) begin
                        drain = 1'b1;
                    end else begin
                        state_d = StStall;
                    end
                end
            end
            StStall: drain = hold_valid_q;
            StGap: begin
                if (gap_cnt_q == GapW'(CsGap - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (drain) begin
            state_d    = StShift;
            shift_d    = hold_data_q;
            bit_cnt_d  = BitW'(WordWidth - 1);
            cur_last_d = hold_last_q;
            sclk_d     = 1'b0;
            div_load   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            ready_q      <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            cur_last_q   <= 1'b0;
            gap_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            sclk_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            ready_q      <= !hold_valid_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            cur_last_q   <= cur_last_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_done_q <= frame_done_d;
            sclk_q       <= sclk_d;
            if (accept) begin
                hold_data_q <= bus.data;
                hold_last_q <= bus.last;
            end
        end
    end

`ifdef SPI_WORD_SERIALIZER_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else if (state_d == StStall && state_q != StStall) begin
            underrun_q <= 1'b1;
        end
    end

    assign bus.underrun = underrun_q;
`endif

    assign bus.ready      = ready_q;
    assign bus.sclk       = sclk_q;
    assign bus.mosi       = shift_q[WordWidth-1];
    assign bus.cs_n       = !(state_q == StShift || state_q == StStall);
    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_word_serializer.sv
// Bench for spi_word_serializer: an SPI receiver model reassembles words from
// the pins and is compared with the words handed in. Index 0 = ClkDiv 2, 1 = ClkDiv 1.
module tb_spi_word_serializer;
    import spi_word_serializer_pkg::*;

    localparam int unsigned Ww     = 32;
    localparam int unsigned CsGap  = 4;
    localparam int          Budget = 6000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_word_serializer_if #(.WordWidth(Ww)) bus2 ();
    spi_word_serializer_if #(.WordWidth(Ww)) bus1 ();

    spi_word_serializer #(.WordWidth(Ww), .ClkDiv(2), .CsGap(CsGap)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );
    spi_word_serializer #(.WordWidth(Ww), .ClkDiv(1), .CsGap(CsGap)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic m_sclk [2], m_mosi [2], m_cs [2], m_fd [2], m_rdy [2], m_busy [2];
    assign m_sclk[0] = bus2.sclk;       assign m_sclk[1] = bus1.sclk;
    assign m_mosi[0] = bus2.mosi;       assign m_mosi[1] = bus1.mosi;
    assign m_cs[0]   = bus2.cs_n;       assign m_cs[1]   = bus1.cs_n;
    assign m_fd[0]   = bus2.frame_done; assign m_fd[1]   = bus1.frame_done;
    assign m_rdy[0]  = bus2.ready;      assign m_rdy[1]  = bus1.ready;
    assign m_busy[0] = bus2.busy;       assign m_busy[1] = bus1.busy;

    // SPI receiver model: sample MOSI on each SCLK rise while CS is low.
    logic [31:0] rx2 [$];
    logic [31:0] rx1 [$];
    logic [31:0] exp_q [$];
    logic [31:0] acc [2];
    int rise_cnt [2] = '{0, 0};
    int fd_cnt [2]   = '{0, 0};
    int low_run [2]  = '{0, 0};
    int low_len [2]  = '{0, 0};
    int high_run [2] = '{0, 0};
    int high_len [2] = '{0, 0};
    int nbits [2]    = '{0, 0};
    int unstable [2] = '{0, 0};
    logic prev_sclk [2] = '{1'b0, 1'b0};
    logic prev_mosi [2] = '{1'b0, 1'b0};
    logic prev_cs [2]   = '{1'b1, 1'b1};

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (m_cs[k] === 1'b0) begin
                if (prev_cs[k]) begin
                    high_len[k] = high_run[k];
                    low_run[k]  = 0;
                    nbits[k]    = 0;
                end
                low_run[k]++;
                if (m_sclk[k] && !prev_sclk[k]) begin
                    rise_cnt[k]++;
                    if (m_mosi[k] !== prev_mosi[k]) unstable[k]++;
                    acc[k] = {acc[k][30:0], m_mosi[k]};
                    nbits[k]++;
                    if (nbits[k] == 32) begin
                        nbits[k] = 0;
                        if (k == 0) rx2.push_back(acc[k]);
                        else rx1.push_back(acc[k]);
                    end
                end
            end else begin
                if (!prev_cs[k]) begin
                    low_len[k]  = low_run[k];
                    high_run[k] = 0;
                end
                high_run[k]++;
            end
            if (m_fd[k] === 1'b1) fd_cnt[k]++;
            prev_sclk[k] = m_sclk[k];
            prev_mosi[k] = m_mosi[k];
            prev_cs[k]   = m_cs[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [31:0] d, input logic l);
        if (k == 0) begin
            bus2.valid = v; bus2.data = d; bus2.last = l;
        end else begin
            bus1.valid = v; bus1.data = d; bus1.last = l;
        end
    endtask

    // Drop valid and scramble data/last: they must be ignored without a transfer.
    task automatic idle(input int k);
        drive(k, 1'b0, $urandom, 1'($urandom));
    endtask

    // Returns the accept cycle t; on return the bench sits in cycle t+1.
    task automatic push(input int k, input logic [31:0] d, input logic l, output int t_acc);
        int n = 0;
        drive(k, 1'b1, d, l);
        while (m_rdy[k] !== 1'b1 && n < Budget) begin
            tick();
            n++;
        end
        check("push_timeout", 32'(n < Budget), 1);
        t_acc = cyc;
        if (k == 0) exp_q.push_back(d);
        tick();
    endtask

    task automatic wait_fd(input int k, input int start, input string tag);
        int n = 0;
        while (fd_cnt[k] == start && n < Budget) begin
            tick();
            n++;
        end
        check(tag, fd_cnt[k], start + 1);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while ((m_busy[k] !== 1'b0 || m_rdy[k] !== 1'b1) && n < Budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < Budget), 1);
    endtask

    task automatic wait_cs_low(input int k);
        int n = 0;
        while (m_cs[k] !== 1'b0 && n < Budget) begin
            tick();
            n++;
        end
        check("cs_low_timeout", 32'(n < Budget), 1);
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] want, got;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = 'x;
            if (rx2.size() > 0) got = rx2.pop_front();
            check(tag, got, want);
        end
        check({tag, "_extra"}, rx2.size(), 0);
    endtask

    initial begin
        int t, s, base_fd, base_rise, viol, nfr;
        logic [31:0] w;
        logic l;

        idle(0);
        idle(1);
        repeat (3) tick();
        check("rst_cs_n", bus2.cs_n, 1);
        check("rst_sclk", bus2.sclk, 0);
        check("rst_mosi", bus2.mosi, 0);
        check("rst_ready", bus2.ready, 0);
        check("rst_busy", bus2.busy, 0);
        check("rst_frame_done", bus2.frame_done, 0);
`ifdef SPI_WORD_SERIALIZER_UNDERRUN_EN
        check("rst_underrun", bus2.underrun, 0);
`endif
        rst = 1'b0;
        tick();
        check("ready_after_rst", bus2.ready, 1);

        // Single one-word frame, latency and pulse shape.
        base_fd = fd_cnt[0]; base_rise = rise_cnt[0];
        w = 32'hA5A50F0F;
        push(0, w, 1'b1, t);
        idle(0);
        check("single_t1_cs_n", bus2.cs_n, 1);
        check("single_t1_ready", bus2.ready, 0);
        tick();
        check("single_t2_cs_n", bus2.cs_n, 0);
        check("single_t2_mosi", bus2.mosi, w[31]);
        check("single_t2_sclk", bus2.sclk, 0);
        tick();
        check("single_t3_sclk", bus2.sclk, 0);
        tick();
        check("single_t4_sclk", bus2.sclk, 1);
        wait_fd(0, base_fd, "single_fd");
        check("single_fd_level", bus2.frame_done, 1);
        check("single_cs_low_len", low_len[0], 128);
        check("single_rises", rise_cnt[0] - base_rise, 32);
        tick();
        check("single_fd_one_cycle", bus2.frame_done, 0);
        check_rx("single_word");

        // Back-to-back words with valid held high: one unbroken 512-cycle frame.
        wait_idle(0);
        base_fd = fd_cnt[0]; base_rise = rise_cnt[0];
        push(0, 32'h00000001, 1'b0, t);
        push(0, 32'h80000000, 1'b0, t);
        push(0, 32'hFFFFFFFF, 1'b0, t);
        push(0, 32'h12345678, 1'b1, t);
        idle(0);
        wait_fd(0, base_fd, "b2b_fd");
        check("b2b_cs_low_len", low_len[0], 512);
        check("b2b_rises", rise_cnt[0] - base_rise, 128);
        check_rx("b2b_word");
`ifdef SPI_WORD_SERIALIZER_UNDERRUN_EN
        check("no_underrun_yet", bus2.underrun, 0);
`endif

        // Underrun: second word arrives long after the first finished.
        wait_idle(0);
        base_fd = fd_cnt[0]; base_rise = rise_cnt[0];
        push(0, 32'hC3C3_1234, 1'b0, t);
        idle(0);
        repeat (140) tick();
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus2.sclk !== 1'b0 || bus2.cs_n !== 1'b0) viol++;
            tick();
        end
        check("stall_pins", viol, 0);
        check("stall_busy", bus2.busy, 1);
`ifdef SPI_WORD_SERIALIZER_UNDERRUN_EN
        check("underrun_set", bus2.underrun, 1);
`endif
        w = 32'h7E57_0001;
        push(0, w, 1'b1, s);
        idle(0);
        check("reload_s1_cs_n", bus2.cs_n, 0);
        tick();
        check("reload_s2_mosi", bus2.mosi, w[31]);
        check("reload_s2_sclk", bus2.sclk, 0);
        tick();
        check("reload_s3_sclk", bus2.sclk, 0);
        tick();
        check("reload_s4_sclk", bus2.sclk, 1);
        wait_fd(0, base_fd, "underrun_fd");
        // CS low from t+2 through the stall up to s+1, then one full word.
        check("underrun_cs_low_len", low_len[0], (s - t) + 128);
        check("underrun_rises", rise_cnt[0] - base_rise, 64);
        check_rx("underrun_word");

        // Frame gap: second frame queued in hold, third accepted during GAP.
        wait_idle(0);
        base_fd = fd_cnt[0];
        push(0, 32'h0F0F_F0F0, 1'b1, t);
        push(0, 32'h3333_CCCC, 1'b1, t);
        idle(0);
        wait_fd(0, base_fd, "gap_fd1");
        viol = 0;
        while (bus2.cs_n === 1'b1 && high_run[0] < Budget) begin
            if (bus2.ready !== 1'b0) viol++;
            tick();
        end
        check("gap_ready_low", viol, 0);
        check("gap_len_held", high_len[0], CsGap + 1);
        check("gap_ready_after_load", bus2.ready, 1);
        wait_fd(0, base_fd + 1, "gap_fd2");
        push(0, 32'hDEAD_BEEF, 1'b1, t);
        idle(0);
        check("gap_accept_ready", bus2.ready, 0);
        check("gap_accept_cs_n", bus2.cs_n, 1);
        wait_cs_low(0);
        check("gap_len_accepted", high_len[0], CsGap + 1);
        wait_fd(0, base_fd + 2, "gap_fd3");
        check_rx("gap_word");
`ifdef SPI_WORD_SERIALIZER_UNDERRUN_EN
        check("underrun_sticky", bus2.underrun, 1);
`endif

        // Random words, frame boundaries and upstream delays.
        wait_idle(0);
        base_fd = fd_cnt[0]; base_rise = rise_cnt[0];
        nfr = 0;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            l = (i == 7) || ($urandom_range(0, 3) == 0);
            if (l) nfr++;
            push(0, w, l, t);
            idle(0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(100, 200)) tick();
            else repeat ($urandom_range(0, 20)) tick();
        end
        wait_idle(0);
        check("rand_frames", fd_cnt[0] - base_fd, nfr);
        check("rand_rises", rise_cnt[0] - base_rise, 8 * 32);
        check_rx("rand_word");
        check("mosi_stable_div2", unstable[0], 0);

        // Reset during bit 10 with a second word waiting in hold.
        base_fd = fd_cnt[0]; base_rise = rise_cnt[0];
        push(0, 32'hFACE_B00C, 1'b1, t);
        push(0, 32'h1111_2222, 1'b1, t);
        idle(0);
        exp_q.delete();
        viol = 0;
        while (rise_cnt[0] - base_rise < 22 && viol < Budget) begin
            tick();
            viol++;
        end
        check("midrst_reach_bit10", 32'(viol < Budget), 1);
        rst = 1'b1;
        tick();
        check("midrst_cs_n", bus2.cs_n, 1);
        check("midrst_sclk", bus2.sclk, 0);
        check("midrst_ready", bus2.ready, 0);
        check("midrst_busy", bus2.busy, 0);
        rst = 1'b0;
        tick();
        check("midrst_ready_release", bus2.ready, 1);
`ifdef SPI_WORD_SERIALIZER_UNDERRUN_EN
        check("midrst_underrun_cleared", bus2.underrun, 0);
`endif
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus2.cs_n !== 1'b1) viol++;
            tick();
        end
        check("midrst_hold_discarded", viol, 0);
        check("midrst_no_frame_done", fd_cnt[0] - base_fd, 0);
        check("midrst_no_word", rx2.size(), 0);

        // ClkDiv = 1: SCLK toggles every cycle, 64-cycle word.
        base_fd = fd_cnt[1]; base_rise = rise_cnt[1];
        w = 32'h5555AAAA;
        push(1, w, 1'b1, t);
        idle(1);
        check("div1_t1_cs_n", bus1.cs_n, 1);
        tick();
        check("div1_t2_cs_n", bus1.cs_n, 0);
        check("div1_t2_mosi", bus1.mosi, w[31]);
        check("div1_t2_sclk", bus1.sclk, 0);
        tick();
        check("div1_t3_sclk", bus1.sclk, 1);
        tick();
        check("div1_t4_sclk", bus1.sclk, 0);
        wait_fd(1, base_fd, "div1_fd");
        check("div1_cs_low_len", low_len[1], 64);
        check("div1_rises", rise_cnt[1] - base_rise, 32);
        check("div1_word", (rx1.size() > 0) ? rx1.pop_front() : 32'hxxxx_xxxx, w);
        check("mosi_stable_div1", unstable[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_word_serializer.md
Name: spi_word_serializer

Overview:
- Downstream neighbour of the buffer-reader stage: one instance per SPI channel.
- Accepts 32-bit words over a valid/ready handshake and shifts them out MSB-first as SPI mode 0 (SCLK idle low, sample on rising edge).
- Frames words under one chip-select, with a guaranteed CS-high gap between frames.
- A one-word holding register allows gap-free back-to-back words within a frame.

Parameters:
- WORD_WIDTH, 32, bits per accepted word; matches buffer block width.
- CLK_DIV, 2, I_clk cycles per SCLK half-period; legal range 1..255.
- CS_GAP, 4, minimum I_clk cycles O_cs_n stays high between frames; must be >= 1.

Ports:
- I_clk, input, 1, system clock.
- I_rst, input, 1, reset; one clock, reset is synchronous and active-high.
- I_data, input, WORD_WIDTH, word to transmit.
- I_valid, input, 1, I_data valid.
- I_last, input, 1, qualifies I_data as final word of the frame.
- O_ready, output, 1, holding register empty; a transfer occurs on I_valid && O_ready.
- O_sclk, output, 1, SPI clock.
- O_mosi, output, 1, SPI data.
- O_cs_n, output, 1, active-low chip select.
- O_busy, output, 1, high whenever state != IDLE.
- O_frame_done, output, 1, one-cycle pulse on the cycle O_cs_n returns high after the last word.

Behaviour:
- Reset values: O_sclk=0, O_mosi=0, O_cs_n=1, O_ready=0, O_busy=0, O_frame_done=0.
  - O_ready rises the first cycle after I_rst deasserts.
  - Holding register, shift register and counters are cleared.
- Reset mid-frame: aborts immediately. O_cs_n=1 and O_sclk=0 the next cycle, no O_frame_done, held word discarded.
- Holding register: O_ready is registered, equal to !hold_valid.
  - It is set by an accepted transfer; data and last are captured.
  - It is cleared when its word is moved into the shift register.
  - A fill and a drain in the same cycle keep it full (O_ready stays 0).
- States:
  - IDLE: O_cs_n=1, O_sclk=0. If hold_valid, load the shift register from hold, go to SHIFT.
  - SHIFT: O_cs_n=0. Each bit is a low phase of CLK_DIV cycles (O_mosi stable, first bit's low phase is the CS setup) followed by a high phase of CLK_DIV cycles. MSB first. Bit counter runs WORD_WIDTH-1 down to 0.
  - End of a word (end of the high phase of bit 0):
    - word was last → go to GAP, O_sclk=0.
    - else hold_valid → reload, continue SHIFT with no extra cycles.
    - else → STALL.
  - STALL: O_cs_n=0, O_sclk=0, O_mosi holds the last bit. When hold_valid, reload and re-enter SHIFT; the low phase restarts with a full CLK_DIV.
  - GAP: O_cs_n=1, O_frame_done pulses on entry cycle. Count CS_GAP cycles, then go to IDLE. A word may be accepted into hold during GAP but is not started until IDLE.
- Latency: word accepted at cycle t (from IDLE, hold empty) → hold_valid at t+1 → IDLE load at t+1 → SHIFT with O_cs_n=0 and O_mosi=MSB at t+2. First SCLK rise at t+2+CLK_DIV.
- Throughput: 2*CLK_DIV*WORD_WIDTH cycles per word; continuous when upstream refills hold within one word time.
- I_last on a single word yields a one-word frame.
- I_data/I_last are ignored when no transfer occurs.
- The divider counter is CLK_DIV-wide ($clog2(256) = 8 bits). The bit counter is $clog2(WORD_WIDTH) bits and wraps only via reload.

Optional Feature:
- Macro: SPI_WORD_SERIALIZER_UNDERRUN_EN
- Defined: adds output O_underrun (1 bit, reset 0). It is a sticky flag, set on every entry to STALL and cleared only by I_rst. It is sticky across frames.
- Undefined: port absent; STALL behaviour unchanged.

Decomposition:
- Shared package spi_out_pkg:
  - typedef enum spi_ser_state_t {IDLE, SHIFT, STALL, GAP}.
  - constant SPI_WORD_WIDTH=32.
  - CLK_DIV width localparam.
- Natural sub-module: spi_clk_divider. It is a phase counter emitting half-period tick and rise/fall strobes, and is restartable by a load strobe.

Test Plan:
- Reset mid-frame: I_rst high during bit 10 of a word → next cycle O_cs_n=1, O_sclk=0, O_ready=0. Then O_ready=1 one cycle after release, and no O_frame_done.
- Single word: CLK_DIV=2, I_data=0xA5A50F0F, I_last=1 → 32 rising edges sampling 0xA5A50F0F. O_cs_n low for 128 cycles, O_frame_done pulse, O_cs_n high ≥4 cycles.
- Back-to-back: 4 words 0x00000001, 0x80000000, 0xFFFFFFFF, 0x12345678 (last on 4th), I_valid always high → 128 SCLK edges with no stall. O_cs_n continuously low for 512 cycles.
- Underrun: 2-word frame, second word delayed 100 cycles → SCLK low and O_cs_n low during the wait. Second word sent correctly; O_underrun=1 if enabled.
- Frame gap: two 1-word frames presented back-to-back → O_cs_n high exactly CS_GAP=4 cycles minimum between them. Second word accepted during GAP; O_ready=0 until it loads.
- CLK_DIV=1: word 0x5555AAAA → SCLK toggles every cycle; 64-cycle word; MOSI stable at each rising edge.
